// File: rtl/simon_key_schedule.sv
// ---------------------------------------------------------------------------
// simon_key_schedule
//   Simon 128/128 key expansion. Loads a 128-bit master key on start_i. Then
//   streams the 68 round keys k0..k67 to the round stage over a valid/ready
//   handshake, one key per accepted transfer.
//
//   Ports
//     clk, rst_n      clock (rising edge), asynchronous active-low reset
//     start_i         load key_i and begin expansion (honoured in IDLE only)
//     key_i[127:0]    master key, key_i[63:0]=k0, key_i[127:64]=k1
//     rk_o[63:0]      current round key k_i
//     rk_valid_o      rk_o holds a valid round key
//     rk_ready_i      consumer accepts rk_o when rk_valid_o && rk_ready_i
//     busy_o          expansion in progress
//     done_o          one-cycle pulse after k67 is accepted
//     rnd_idx_o[6:0]  index of rk_o (only when SIMON_KS_RNDIDX_EN is defined)
//
//   Build option
//     SIMON_KS_RNDIDX_EN : adds rnd_idx_o so the round stage can confirm that
//                          keys and rounds stay aligned.
// ---------------------------------------------------------------------------
module simon_key_schedule #(
    parameter int WORD   = 64,   // only 64 is supported
    parameter int ROUNDS = 68
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [2*WORD-1:0] key_i,
    output logic [WORD-1:0]   rk_o,
    output logic              rk_valid_o,
    input  logic              rk_ready_i,
    output logic              busy_o,
    output logic              done_o
`ifdef SIMON_KS_RNDIDX_EN
    ,
    output logic [6:0]        rnd_idx_o
`endif
);

    // z2 sequence. Ascending range so that Z2[0] is the leftmost bit.
    localparam logic [0:61] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [WORD-1:0] r_ka;     // current key, drives rk_o
    logic [WORD-1:0] r_kb;     // next key
    logic [6:0]      r_cnt;    // index of r_ka
    logic [5:0]      r_j;      // z2 bit used for the key produced next
    logic            r_done;

    logic            w_hs;
    logic            w_last;
    logic [WORD-1:0] w_t;
    logic [WORD-1:0] w_knew;

    assign w_hs   = (r_state == S_RUN) && rk_ready_i;
    assign w_last = w_hs && (r_cnt == 7'(ROUNDS - 1));

    // k(i+2) = ~k(i) ^ t ^ (t ror 1) ^ z ^ 3, where t = k(i+1) ror 3.
    // ~x ^ 3 is the round constant c = 2^64-4 folded into k(i).
    assign w_t    = {r_kb[2:0], r_kb[WORD-1:3]};
    assign w_knew = ~r_ka ^ w_t ^ {w_t[0], w_t[WORD-1:1]}
                  ^ {{(WORD-1){1'b0}}, Z2[r_j]} ^ WORD'(3);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. start_i is ignored in RUN.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_state_nxt = S_RUN;
            S_RUN:   if (w_last)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Key datapath. Without a handshake, everything holds, so rk_o stays
    // stable under back-pressure. After the last key, r_ka keeps k67.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ka   <= '0;
            r_kb   <= '0;
            r_cnt  <= '0;
            r_j    <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
            if (r_state == S_IDLE && start_i) begin
                r_ka  <= key_i[WORD-1:0];
                r_kb  <= key_i[2*WORD-1:WORD];
                r_cnt <= '0;
                r_j   <= '0;
            end else if (w_hs && !w_last) begin
                r_ka  <= r_kb;
                r_kb  <= w_knew;
                r_cnt <= r_cnt + 7'd1;
                r_j   <= (r_j == 6'd61) ? 6'd0 : r_j + 6'd1;
            end
        end
    end

    // All outputs come straight from flops (state decode included).
    assign rk_o       = r_ka;
    assign rk_valid_o = (r_state == S_RUN);
    assign busy_o     = (r_state == S_RUN);
    assign done_o     = r_done;

`ifdef SIMON_KS_RNDIDX_EN
    assign rnd_idx_o  = r_cnt;
`endif

endmodule
